stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr_if.sv | 30 +++
 rtl/stream_mux_rr.sv | 159 +++++++++++++++
 tb/tb_stream_mux_rr.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr.
// Carries N input channels (packed data, valid, last, ready) and the single
// registered output channel (data, last, source index, valid, ready).
//   master : the side that drives input beats and accepts output beats
//   slave  : the multiplexer itself
interface stream_mux_rr_if #(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) ();
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_last, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_last, out_sel, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Packet-aware N:1 stream multiplexer with a single registered output stage.
// Arbitration is round-robin (mode=0, rotating from the last granted channel)
// or fixed select (mode=1, channel S). Once a multi-beat packet starts, the
// source channel is locked until its last beat passes, so packets are never
// interleaved on the output.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   mode  : 0 = round-robin, 1 = fixed select
//   S     : channel select used in fixed-select mode (values >= N grant nothing)
//   bus   : stream bundle (slave side): N inputs, one registered output
module stream_mux_rr #(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [SW-1:0] S,
    stream_mux_rr_if.slave bus
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_reg;
    logic [SW-1:0] ptr_reg;
    logic [SW-1:0] lock_ch_reg;
    logic [W-1:0]  out_data_reg;
    logic          out_last_reg;
    logic [SW-1:0] out_sel_reg;
    logic          out_valid_reg;

    logic [SW-1:0] grant;
    logic          grant_vld;
    logic [SW-1:0] rr_grant;
    logic          rr_vld;
    int            rr_best;
    int            rr_dist;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic          load_en;
    logic          xfer;

    // Round-robin search: each channel's distance from ptr+1 (mod N) is
    // computed with a constant channel index, and the nearest valid channel
    // wins. ptr_reg always holds a legal index, so the distance never goes
    // negative.
    always_comb begin
        rr_best  = N;
        rr_dist  = 0;
        rr_grant = '0;
        for (int k = 0; k < N; k++) begin
            rr_dist = k + N - 1 - int'(ptr_reg);
            if (rr_dist >= N) begin
                rr_dist = rr_dist - N;
            end
            if (bus.in_valid[k] && (rr_dist < rr_best)) begin
                rr_best  = rr_dist;
                rr_grant = SW'(k);
            end
        end
        rr_vld = (rr_best < N);
    end

    // Grant selection. While locked, only the owning channel is considered,
    // so mode/S changes are deferred until the packet completes.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        if (state_reg == LOCK) begin
            grant = lock_ch_reg;
            for (int k = 0; k < N; k++) begin
                if (lock_ch_reg == SW'(k)) begin
                    grant_vld = bus.in_valid[k];
                end
            end
        end else if (mode) begin
            // An out-of-range S matches no channel and leaves grant_vld low.
            grant = S;
            for (int k = 0; k < N; k++) begin
                if (S == SW'(k)) begin
                    grant_vld = bus.in_valid[k];
                end
            end
        end else begin
            grant     = rr_grant;
            grant_vld = rr_vld;
        end
    end

    // Beat of the granted channel.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (grant == SW'(k)) begin
                sel_data = bus.in_data[k*W +: W];
                sel_last = bus.in_last[k];
            end
        end
    end

    assign load_en = !out_valid_reg || bus.out_ready;
    // Gating with rst_n keeps every in_ready low during a reset cycle.
    assign xfer    = rst_n && load_en && grant_vld;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign bus.in_ready[gi] = xfer && (grant == SW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= SW'(N - 1);
            lock_ch_reg   <= '0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (xfer) begin
                out_data_reg  <= sel_data;
                out_last_reg  <= sel_last;
                out_sel_reg   <= grant;
                out_valid_reg <= 1'b1;
                // In LOCK grant equals lock_ch, so ptr effectively moves once
                // per packet rather than once per beat.
                if (!mode) begin
                    ptr_reg <= grant;
                end
                case (state_reg)
                    IDLE: begin
                        if (!sel_last) begin
                            state_reg   <= LOCK;
                            lock_ch_reg <= grant;
                        end
                    end
                    LOCK: begin
                        if (sel_last) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_sel   = out_sel_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=8, W=8, SW=4 so that S=9 is
// representable). A behavioural model in terms of "owner channel" and
// "last served channel" predicts in_ready and the output register every
// cycle; directed scenarios add literal expectations, and a randomized
// phase adds a per-channel ordering / contiguity scoreboard.
module tb_stream_mux_rr;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 4;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic [SW-1:0] S;

    stream_mux_rr_if #(.N(N), .W(W), .SW(SW)) bus ();

    stream_mux_rr #(.N(N), .W(W), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .S     (S),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] src_q [N][$];   // pending input beats {last, data}
    logic [8:0] exp_q [N][$];   // scoreboard copy of beats pushed
    logic [N-1:0] en_mask;
    beat_t      log_q [$];      // output transfers seen on the DUT
    bit         mon_en;
    bit         sb_en;
    bit         sb_open;
    int         sb_prev;
    int         pkt_cnt [N];

    // Model state
    bit         m_ov;
    logic [7:0] m_od;
    logic       m_ol;
    int         m_os;
    int         m_owner;        // -1 when no packet is owned
    int         m_prev;         // last served channel in round-robin

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_drain(input int bound, input string nm);
        int n;
        n = 0;
        while (!(all_empty() && !bus.out_valid) && n < bound) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk(nm, (n < bound), 1);
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic l);
        src_q[ch].push_back({l, d});
        if (sb_en) exp_q[ch].push_back({l, d});
    endtask

    // Source driver: pops accepted beats and presents the next head.
    initial begin : driver
        logic [N-1:0]   acc;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [N*W-1:0] d;
        bus.in_valid = '0;
        bus.in_last  = '0;
        bus.in_data  = '0;
        forever begin
            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            v = '0;
            l = '0;
            d = '0;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0 && en_mask[k]) begin
                    v[k]         = 1'b1;
                    l[k]         = src_q[k][0][8];
                    d[k*W +: W]  = src_q[k][0][7:0];
                end
            end
            bus.in_valid = v;
            bus.in_last  = l;
            bus.in_data  = d;
        end
    end

    // Compare process: checks DUT against the model, logs transfers,
    // runs the scoreboard, then advances the model by one clock.
    always @(negedge clk) begin : compare
        int          g;
        bit          ok;
        logic [N-1:0] exp_rdy;
        logic [8:0]  e;
        int          s;
        g  = 0;
        ok = 1'b0;
        if (!rst_n) begin
            exp_rdy = '0;
        end else begin
            if (m_owner >= 0) begin
                g  = m_owner;
                ok = bus.in_valid[g];
            end else if (mode) begin
                if (int'(S) < N) begin
                    g  = int'(S);
                    ok = bus.in_valid[g];
                end
            end else begin
                for (int step = 1; step <= N; step++) begin
                    if (bus.in_valid[(m_prev + step) % N]) begin
                        g  = (m_prev + step) % N;
                        ok = 1'b1;
                        break;
                    end
                end
            end
            exp_rdy = (ok && (!m_ov || bus.out_ready)) ? N'(1 << g) : '0;
        end

        if (mon_en) begin
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("out_valid", bus.out_valid, m_ov);
            chk("out_data", bus.out_data, m_od);
            chk("out_last", bus.out_last, m_ol);
            chk("out_sel", bus.out_sel, m_os);

            if (bus.out_valid && bus.out_ready) begin
                s = int'(bus.out_sel);
                log_q.push_back('{sel: s, data: bus.out_data, last: bus.out_last});
                if (sb_en && s < N) begin
                    if (sb_open) chk("contiguous", s, sb_prev);
                    chk("sb_avail", (exp_q[s].size() > 0), 1);
                    if (exp_q[s].size() > 0) begin
                        e = exp_q[s].pop_front();
                        chk("sb_beat", {bus.out_last, bus.out_data}, e);
                    end
                    sb_open = !bus.out_last;
                    sb_prev = s;
                    if (bus.out_last) pkt_cnt[s]++;
                end
            end
        end

        if (!rst_n) begin
            m_ov    = 1'b0;
            m_od    = '0;
            m_ol    = 1'b0;
            m_os    = 0;
            m_owner = -1;
            m_prev  = N - 1;
        end else if (exp_rdy != '0) begin
            m_ov = 1'b1;
            m_od = 8'(bus.in_data >> (g * W));
            m_ol = bus.in_last[g];
            m_os = g;
            if (!mode) m_prev = g;
            m_owner = m_ol ? -1 : g;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
    end

    initial begin : main
        rst_n         = 1'b0;
        mode          = 1'b0;
        S             = '0;
        bus.out_ready = 1'b1;
        en_mask       = '1;
        mon_en        = 1'b0;
        sb_en         = 1'b0;
        sb_open       = 1'b0;
        sb_prev       = 0;
        for (int k = 0; k < N; k++) pkt_cnt[k] = 0;

        // Reset state
        cyc(2);
        mon_en = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sel", bus.out_sel, 0);
        chk("rst_out_data", bus.out_data, 0);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);

        // All channels valid, single-beat packets: rotation 0..7,0
        cyc(1);
        rst_n = 1'b1;
        log_q.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 8'(8'h10 + k + 8 * r), 1'b1);
        cyc(1);
        @(negedge clk);
        chk("first_grant_ch0", bus.in_ready, 8'h01);
        wait_drain(200, "drain_rr");
        chk("rr_count", log_q.size(), 16);
        for (int i = 0; i < 9 && i < log_q.size(); i++)
            chk($sformatf("rr_sel%0d", i), log_q[i].sel, i % 8);

        // 3-beat packet on ch2 while ch5 is valid: no interleaving
        log_q.delete();
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        push(5, 8'h51, 1'b0); push(5, 8'h52, 1'b1);
        wait_drain(200, "drain_pkt");
        chk("pkt_count", log_q.size(), 5);
        if (log_q.size() == 5) begin
            chk("pkt_sel0", log_q[0].sel, 2);
            chk("pkt_sel1", log_q[1].sel, 2);
            chk("pkt_sel2", log_q[2].sel, 2);
            chk("pkt_last2", log_q[2].last, 1);
            chk("pkt_sel3", log_q[3].sel, 5);
            chk("pkt_data4", log_q[4].data, 8'h52);
        end

        // Fixed select S=6, then out-of-range S=9
        log_q.delete();
        mode = 1'b1;
        S    = 4'd6;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 3; i++) push(k, 8'(8'h60 + 8 * k + i), 1'b1);
        cyc(10);
        chk("fix_count", log_q.size(), 3);
        for (int i = 0; i < log_q.size(); i++)
            chk($sformatf("fix_sel%0d", i), log_q[i].sel, 6);
        S = 4'd9;
        log_q.delete();
        cyc(6);
        chk("s9_no_xfer", log_q.size(), 0);
        @(negedge clk);
        chk("s9_in_ready", bus.in_ready, 0);
        cyc(1);
        mode = 1'b0;
        wait_drain(300, "drain_fix");

        // Output stall for 4 cycles
        log_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4, 8'(8'hA0 + i), 1'b1);
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, 8'hA0);
            chk("stall_sel", bus.out_sel, 4);
            cyc(1);
        end
        bus.out_ready = 1'b1;
        wait_drain(100, "drain_stall");
        chk("stall_count", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            chk($sformatf("stall_data%0d", i), log_q[i].data, 8'(8'hA0 + i));

        // Reset during beat 2 of a 4-beat ch3 packet
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
        cyc(2);
        push(1, 8'h11, 1'b1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        log_q.delete();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("mid_rst_grant_ch1", bus.in_ready, 8'h02);
        wait_drain(100, "drain_rst");
        chk("mid_rst_first_sel", (log_q.size() > 0) ? log_q[0].sel : -1, 1);

        // Randomized traffic with scoreboard
        sb_en   = 1'b1;
        sb_open = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() < 6 && $urandom_range(0, 9) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(k, 8'($urandom), (b == len - 1));
                end
                en_mask[k] = ($urandom_range(0, 9) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (c == 8000) begin
                for (int k = 0; k < N; k++)
                    chk($sformatf("no_starve_ch%0d", k), (pkt_cnt[k] > 0), 1);
            end
            if (c >= 8000 && c % 50 == 0) begin
                mode = 1'($urandom_range(0, 1));
                S    = SW'($urandom_range(0, 9));
            end
            cyc(1);
        end
        mode          = 1'b0;
        en_mask       = '1;
        bus.out_ready = 1'b1;
        wait_drain(3000, "drain_random");
        for (int k = 0; k < N; k++)
            chk($sformatf("sb_empty_ch%0d", k), exp_q[k].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
